// File: rtl/ps2_mouse_packet_pkg.sv
// ---------------------------------------------------------------------------
// ps2_mouse_packet_pkg
// Shared definitions for the PS/2 mouse packet assembler and its consumers:
//   - status byte bit positions (buttons L/R/M occupy bits 0..2)
//   - field offsets inside the 25-bit ps2_mouse bus
//   - overflow saturation helper for one movement byte
// ---------------------------------------------------------------------------
package ps2_mouse_packet_pkg;

  // Status byte bit positions
  localparam int SYNC = 3;  // always 1 in a genuine first byte
  localparam int XS   = 4;  // X sign
  localparam int YS   = 5;  // Y sign
  localparam int XO   = 6;  // X overflow
  localparam int YO   = 7;  // Y overflow

  // ps2_mouse bus layout: {TOGGLE, DY[7:0], DX[7:0], ST[7:0]}
  localparam int TOGGLE = 24;
  localparam int DY_LSB = 16;
  localparam int DX_LSB = 8;
  localparam int ST_LSB = 0;

  // Clamp a 9-bit signed delta {sign, delta} to its extreme when the mouse
  // reports overflow: negative -> -256 (low byte 00), positive -> +255 (FF).
  // The sign bit lives in the status byte and is never modified here.
  function automatic logic [7:0] sat_delta(input logic       ovf,
                                           input logic       sign,
                                           input logic [7:0] delta);
    if (ovf) begin
      sat_delta = sign ? 8'h00 : 8'hFF;
    end else begin
      sat_delta = delta;
    end
  endfunction

endpackage

// File: rtl/ps2_mouse_packet_gap_timer.sv
// ---------------------------------------------------------------------------
// ps2_gap_timer
// Inter-byte gap counter. Counts while enabled, holds at CYCLES, and reports
// expiry while enabled and the count has reached CYCLES.
// Ports:
//   clk_sys  in   system clock
//   reset_n  in   asynchronous active-low reset
//   clr      in   synchronous clear (has priority over counting)
//   en       in   count enable
//   expire   out  gap limit reached (only while en)
// ---------------------------------------------------------------------------
module ps2_gap_timer #(
  parameter int unsigned CYCLES = 96000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = $clog2(CYCLES + 1);
  localparam logic [W-1:0] LIMIT = W'(CYCLES);
  localparam logic [W-1:0] ONE   = W'(1);

  logic [W-1:0] count;

  // Gap counter: clear wins, otherwise count up to LIMIT and hold there
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LIMIT)) begin
      count <= count + ONE;
    end else begin
      count <= count;
    end
  end

  assign expire = en && (count == LIMIT);

endmodule

// File: rtl/ps2_mouse_packet.sv
// ---------------------------------------------------------------------------
// ps2_mouse_packet
// Assembles 3-byte PS/2 mouse packets into the 25-bit ps2_mouse bus with
// sync recovery, inter-byte timeout, overflow saturation and a per-packet
// toggle in bit 24.
// Ports:
//   clk_sys    in   1   system clock
//   reset_n    in   1   asynchronous active-low reset
//   rx_valid   in   1   one-cycle strobe, rx_data holds a byte
//   rx_data    in   8   received byte
//   rx_err     in   1   parity/framing error (qualified by rx_valid)
//   ps2_mouse  out  25  {toggle, dY, dX, status}
//   drop_cnt   out  8   saturating count of discarded bytes/packets
// ---------------------------------------------------------------------------
module ps2_mouse_packet
  import ps2_mouse_packet_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 96000,
  parameter bit          SYNC_CHECK     = 1'b1
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_err,
  output logic [24:0] ps2_mouse,
  output logic [7:0]  drop_cnt
);

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2
  } state_e;

  state_e     state;
  state_e     eff_state;
  state_e     next_state;
  logic [7:0] status_q;
  logic [7:0] dx_q;
  logic       expire;
  logic       good;
  logic       bad;
  logic       sync_fail;
  logic       accept;
  logic       pkt_done;
  logic       drop_ev;
  logic       timer_clr;
  logic       timer_en;

  // Gap timer runs only while a packet is partially received
  always_comb begin
    timer_en = (state == WAIT_B1) || (state == WAIT_B2);
  end

  ps2_gap_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .clr     (timer_clr),
    .en      (timer_en),
    .expire  (expire)
  );

  // Byte classification and next-state decode. A timeout first forces the
  // FSM back to WAIT_B0, so a byte arriving in that cycle is judged as a
  // fresh first-byte candidate.
  always_comb begin
    good      = rx_valid & ~rx_err;
    bad       = rx_valid & rx_err;
    eff_state = expire ? WAIT_B0 : state;
    sync_fail = good && (eff_state == WAIT_B0) && SYNC_CHECK && !rx_data[SYNC];
    accept    = good & ~sync_fail;
    pkt_done  = good && (eff_state == WAIT_B2);
    drop_ev   = expire | bad | sync_fail;
    next_state = eff_state;
    if (bad) begin
      next_state = WAIT_B0;
    end else if (accept) begin
      case (eff_state)
        WAIT_B0: next_state = WAIT_B1;
        WAIT_B1: next_state = WAIT_B2;
        WAIT_B2: next_state = WAIT_B0;
        default: next_state = WAIT_B0;
      endcase
    end else begin
      next_state = eff_state;
    end
    timer_clr = accept || (next_state == WAIT_B0);
  end

  // Packet FSM, byte capture, output bus and drop counter
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= WAIT_B0;
      status_q  <= 8'h00;
      dx_q      <= 8'h00;
      ps2_mouse <= 25'd0;
      drop_cnt  <= 8'h00;
    end else begin
      state <= next_state;
      if (accept && (eff_state == WAIT_B0)) begin
        status_q <= rx_data;
      end else begin
        status_q <= status_q;
      end
      if (accept && (eff_state == WAIT_B1)) begin
        dx_q <= rx_data;
      end else begin
        dx_q <= dx_q;
      end
      if (pkt_done) begin
        ps2_mouse[TOGGLE]            <= ~ps2_mouse[TOGGLE];
        ps2_mouse[DY_LSB+7:DY_LSB]   <= sat_delta(status_q[YO], status_q[YS], rx_data);
        ps2_mouse[DX_LSB+7:DX_LSB]   <= sat_delta(status_q[XO], status_q[XS], dx_q);
        ps2_mouse[ST_LSB+7:ST_LSB]   <= status_q;
      end else begin
        ps2_mouse <= ps2_mouse;
      end
      // Several drop causes in one cycle still count as a single drop
      if (drop_ev && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end else begin
        drop_cnt <= drop_cnt;
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_packet.sv
// ---------------------------------------------------------------------------
// tb_ps2_mouse_packet
// Self-checking bench for ps2_mouse_packet with a reduced timeout. The
// reference model tracks packets as lists of received bytes with cycle
// timestamps; drops are counted as distinct cycles in which a discard occurs.
// ---------------------------------------------------------------------------
module tb_ps2_mouse_packet;

  localparam int T = 200;

  logic        clk_sys  = 1'b0;
  logic        reset_n  = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data  = 8'h00;
  logic        rx_err   = 1'b0;
  logic [24:0] ps2_mouse;
  logic [7:0]  drop_cnt;

  ps2_mouse_packet #(
    .TIMEOUT_CYCLES (T),
    .SYNC_CHECK     (1'b1)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_err    (rx_err),
    .ps2_mouse (ps2_mouse),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_n;          // bytes of current packet already held
  logic [7:0]  m_b0, m_b1;
  int          m_last;       // cycle of the last accepted byte
  int          m_last_drop;  // cycle of the last counted drop
  int          m_drop;
  logic [24:0] m_mouse;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_mouse"}, {7'd0, ps2_mouse}, {7'd0, m_mouse});
    chk({tag, "_drop"}, {24'd0, drop_cnt}, m_drop);
  endtask

  task automatic model_reset();
    m_n = 0; m_b0 = 8'h00; m_b1 = 8'h00; m_last = 0;
    m_last_drop = -1; m_drop = 0; m_mouse = 25'd0;
  endtask

  task automatic model_drop(input int c);
    if (c != m_last_drop) begin
      m_last_drop = c;
      if (m_drop < 255) m_drop++;
    end
  endtask

  // A partial packet expires T+1 cycles after its last accepted byte
  task automatic model_timeout(input int c);
    if (m_n > 0 && c >= m_last + T + 1) begin
      model_drop(m_last + T + 1);
      m_n = 0;
    end
  endtask

  // 9-bit signed movement clamped to [-256, +255] on overflow
  function automatic logic [7:0] sat_ref(input logic ovf, input logic sign, input logic [7:0] b);
    int d;
    logic [31:0] u;
    d = sign ? int'(b) - 256 : int'(b);
    if (ovf) d = sign ? -256 : 255;
    u = d;
    return u[7:0];
  endfunction

  task automatic model_byte(input int c, input logic [7:0] d, input logic e);
    model_timeout(c);
    if (e) begin
      model_drop(c);
      m_n = 0;
    end else begin
      case (m_n)
        0: begin
          if (!d[3]) model_drop(c);
          else begin m_b0 = d; m_n = 1; m_last = c; end
        end
        1: begin m_b1 = d; m_n = 2; m_last = c; end
        default: begin
          m_mouse = {~m_mouse[24], sat_ref(m_b0[7], m_b0[5], d),
                     sat_ref(m_b0[6], m_b0[4], m_b1), m_b0};
          m_n = 0;
        end
      endcase
    end
  endtask

  task automatic send(input logic [7:0] d, input logic e, input int gap);
    repeat (gap) @(negedge clk_sys);
    rx_valid = 1'b1; rx_data = d; rx_err = e;
    @(negedge clk_sys);
    rx_valid = 1'b0; rx_err = 1'b0;
    model_byte(cyc, d, e);
    chk_outputs($sformatf("byte%02h", d));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_sys);
    model_timeout(cyc);
    chk_outputs("idle");
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk_outputs("in_reset");
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    chk_outputs("after_reset");
  endtask

  initial begin
    model_reset();
    do_reset();

    // Basic packet, 100 clocks apart
    send(8'h08, 1'b0, 99); send(8'h05, 1'b0, 99); send(8'hFB, 1'b0, 99);
    chk("basic_const", {7'd0, ps2_mouse}, 32'h01FB0508);
    chk("basic_drop0", {24'd0, drop_cnt}, 32'd0);

    // Out-of-sync first byte is dropped
    send(8'h00, 1'b0, 3);
    send(8'h08, 1'b0, 3); send(8'h05, 1'b0, 3); send(8'hFB, 1'b0, 3);

    // Timeout discards a partial packet
    send(8'h08, 1'b0, 3); send(8'h05, 1'b0, 3);
    idle(T + 5);
    send(8'h18, 1'b0, 3); send(8'h10, 1'b0, 3); send(8'h20, 1'b0, 3);

    // Overflow saturation
    send(8'hF8, 1'b0, 2); send(8'h12, 1'b0, 2); send(8'h34, 1'b0, 2);
    chk("ovf_all", {8'd0, ps2_mouse[23:0]}, 32'h000000F8);
    send(8'h48, 1'b0, 2); send(8'h12, 1'b0, 2); send(8'h34, 1'b0, 2);
    chk("ovf_x_pos", {8'd0, ps2_mouse[23:0]}, 32'h0034FF48);
    send(8'hD8, 1'b0, 2); send(8'h12, 1'b0, 2); send(8'h34, 1'b0, 2);

    // Error on second byte, then a good packet
    send(8'h09, 1'b0, 2); send(8'h55, 1'b1, 2);
    send(8'h09, 1'b0, 2); send(8'h01, 1'b0, 2); send(8'h01, 1'b0, 2);

    // Timeout boundaries: gap of T accepted; gap of T+1 coincides with timeout
    send(8'h0A, 1'b0, 2); send(8'h07, 1'b0, T - 1);
    send(8'h00, 1'b0, T);
    send(8'h28, 1'b0, 2); send(8'h11, 1'b0, 2);
    send(8'h0C, 1'b0, T);
    send(8'h22, 1'b0, 2); send(8'h33, 1'b0, 2);

    // Reset mid-packet
    send(8'h08, 1'b0, 2);
    do_reset();
    send(8'h09, 1'b0, 2); send(8'h01, 1'b0, 2); send(8'h01, 1'b0, 2);
    chk("rst_toggle", {31'd0, ps2_mouse[24]}, 32'd1);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [7:0] d;
      logic       e;
      int         g;
      int         r;
      d = 8'($urandom);
      if (m_n == 0 && $urandom_range(0, 9) < 8) d[3] = 1'b1;
      e = ($urandom_range(0, 19) == 0);
      r = $urandom_range(0, 19);
      case (r)
        0:       g = T - 1;
        1:       g = T;
        2:       g = T + 2;
        default: g = $urandom_range(0, 6);
      endcase
      send(d, e, g);
    end
    idle(T + 3);

    // Drop counter saturation
    for (int i = 0; i < 270; i++) send(8'hAA, 1'b1, 0);
    chk("drop_sat", {24'd0, drop_cnt}, 32'h000000FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
